open_mem_mp: RTL and testbench

- Parametrised successor to the single-write open memory: a small register bank with two write ports and per-byte write enables.
- Has two registered random-read ports, a flat all-lanes output bus, and a sequenced lane-by-lane clear engine.
- Serves as the multi-port storage primitive for the myMIPS datapath (register file, small CSR banks) and as a generic lane store.

---
 rtl/open_mem_pkg.sv | 34 +++
 rtl/open_mem_rdport.sv | 36 +++
 rtl/open_mem_mp.sv | 122 ++++++++++++
 tb/tb_open_mem_mp.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/open_mem_pkg.sv
// Shared types and helpers for the multi-port open memory: byte-enable merge,
// clear-FSM state encoding and lane range check.
package open_mem_pkg;

    // Widest lane supported by the merge helper; callers zero-extend and truncate.
    localparam int MAX_DW  = 64;
    localparam int MAX_NBE = MAX_DW / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0]  old_v,
        input logic [MAX_DW-1:0]  new_v,
        input logic [MAX_NBE-1:0] be
    );
        logic [MAX_DW-1:0] r;
        r = old_v;
        for (int j = 0; j < MAX_NBE; j++) begin
            if (be[j]) r[j*8 +: 8] = new_v[j*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic lane_ok(
        input logic [31:0] lane,
        input logic [31:0] nlanes
    );
        return lane < nlanes;
    endfunction

endpackage

// File: rtl/open_mem_rdport.sv
// Registered random-read port: picks a lane from storage, or from the
// post-write lane values when bypass is enabled; out-of-range lanes read 0.
module open_mem_rdport
    import open_mem_pkg::*;
#(
    parameter int AWIDTH = 2,
    parameter int DWIDTH = 8,
    parameter int NLANES = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] i_rlane,
    input  logic [DWIDTH-1:0] i_store [NLANES],
    input  logic [DWIDTH-1:0] i_wnext [NLANES],
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] w_sel;
    logic [DWIDTH-1:0] r_rdata;

    always_comb begin
        w_sel = '0;
        if (lane_ok(32'(i_rlane), 32'(NLANES))) begin
            w_sel = (BYPASS != 0) ? i_wnext[i_rlane] : i_store[i_rlane];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_rdata <= '0;
        else      r_rdata <= w_sel;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/open_mem_mp.sv
// Multi-port lane store: two byte-enabled write ports (B wins on overlap),
// two registered read ports, flat all-lanes view and a lane-by-lane clear engine.
module open_mem_mp
    import open_mem_pkg::*;
#(
    parameter  int AWIDTH     = 2,
    parameter  int DWIDTH     = 8,
    parameter  int NLANES     = 2**AWIDTH,
    parameter  int ZERO_LANE0 = 0,
    parameter  int BYPASS     = 1,
    localparam int NBE        = DWIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_a,
    input  logic [AWIDTH-1:0]        i_wlane_a,
    input  logic [NBE-1:0]           i_wbe_a,
    input  logic [DWIDTH-1:0]        i_wdata_a,
    input  logic                     i_wr_b,
    input  logic [AWIDTH-1:0]        i_wlane_b,
    input  logic [NBE-1:0]           i_wbe_b,
    input  logic [DWIDTH-1:0]        i_wdata_b,
    input  logic [AWIDTH-1:0]        i_rlane_0,
    input  logic [AWIDTH-1:0]        i_rlane_1,
    output logic [DWIDTH-1:0]        o_rdata_0,
    output logic [DWIDTH-1:0]        o_rdata_1,
    input  logic                     i_clr,
    output logic                     o_busy,
    output logic [NLANES*DWIDTH-1:0] o_datalane
);

    state_t            r_state, w_state_nx;
    logic [AWIDTH-1:0] r_cnt, w_cnt_nx;
    logic [DWIDTH-1:0] r_mem  [NLANES];
    logic [DWIDTH-1:0] w_next [NLANES];
    logic              w_wr_a, w_wr_b;

    assign o_busy = (r_state == ST_CLEAR);

    // Writes are dropped while clearing, outside the lane range, and to a hardwired-zero lane 0.
    assign w_wr_a = i_wr_a && !o_busy && lane_ok(32'(i_wlane_a), 32'(NLANES))
                    && !((ZERO_LANE0 != 0) && (i_wlane_a == '0));
    assign w_wr_b = i_wr_b && !o_busy && lane_ok(32'(i_wlane_b), 32'(NLANES))
                    && !((ZERO_LANE0 != 0) && (i_wlane_b == '0));

    // Post-write lane values; B is applied after A so it wins on shared bytes.
    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
            w_next[k] = r_mem[k];
            if (w_wr_a && (i_wlane_a == AWIDTH'(k))) begin
                w_next[k] = DWIDTH'(be_merge(MAX_DW'(w_next[k]), MAX_DW'(i_wdata_a),
                                             MAX_NBE'(i_wbe_a)));
            end
            if (w_wr_b && (i_wlane_b == AWIDTH'(k))) begin
                w_next[k] = DWIDTH'(be_merge(MAX_DW'(w_next[k]), MAX_DW'(i_wdata_b),
                                             MAX_NBE'(i_wbe_b)));
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_nx = ST_CLEAR;
                    w_cnt_nx   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == AWIDTH'(NLANES - 1)) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + AWIDTH'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            // NOTE: this storage is small flops and must read zero after reset, so it is reset explicitly.
            for (int k = 0; k < NLANES; k++) r_mem[k] <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            for (int k = 0; k < NLANES; k++) begin
                if (o_busy && (r_cnt == AWIDTH'(k))) r_mem[k] <= '0;
                else                                 r_mem[k] <= w_next[k];
            end
        end
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_flat
        assign o_datalane[k*DWIDTH +: DWIDTH] = r_mem[k];
    end

    open_mem_rdport #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NLANES(NLANES), .BYPASS(BYPASS)
    ) u_rd0 (
        .clk(clk), .rst(rst), .i_rlane(i_rlane_0),
        .i_store(r_mem), .i_wnext(w_next), .o_rdata(o_rdata_0)
    );

    open_mem_rdport #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NLANES(NLANES), .BYPASS(BYPASS)
    ) u_rd1 (
        .clk(clk), .rst(rst), .i_rlane(i_rlane_1),
        .i_store(r_mem), .i_wnext(w_next), .o_rdata(o_rdata_1)
    );

endmodule

// File: tb/tb_open_mem_mp.sv
// Two open_mem_mp instances (4 lanes/bypass and 6-of-8 lanes/zero-lane0/no-bypass)
// driven by shared stimulus and compared against a per-instance lane model.
module tb_open_mem_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_a, wr_b, clr;
    logic [2:0]  wlane_a, wlane_b, rlane_0, rlane_1;
    logic [1:0]  wbe_a, wbe_b;
    logic [15:0] wdata_a, wdata_b;

    logic [15:0] rd00, rd01, rd10, rd11;
    logic        busy0, busy1;
    logic [63:0] dl0;
    logic [95:0] dl1;

    open_mem_mp #(
        .AWIDTH(2), .DWIDTH(16), .NLANES(4), .ZERO_LANE0(0), .BYPASS(1)
    ) dut0 (
        .clk(clk), .rst(rst),
        .i_wr_a(wr_a), .i_wlane_a(wlane_a[1:0]), .i_wbe_a(wbe_a), .i_wdata_a(wdata_a),
        .i_wr_b(wr_b), .i_wlane_b(wlane_b[1:0]), .i_wbe_b(wbe_b), .i_wdata_b(wdata_b),
        .i_rlane_0(rlane_0[1:0]), .i_rlane_1(rlane_1[1:0]),
        .o_rdata_0(rd00), .o_rdata_1(rd01),
        .i_clr(clr), .o_busy(busy0), .o_datalane(dl0)
    );

    open_mem_mp #(
        .AWIDTH(3), .DWIDTH(16), .NLANES(6), .ZERO_LANE0(1), .BYPASS(0)
    ) dut1 (
        .clk(clk), .rst(rst),
        .i_wr_a(wr_a), .i_wlane_a(wlane_a), .i_wbe_a(wbe_a), .i_wdata_a(wdata_a),
        .i_wr_b(wr_b), .i_wlane_b(wlane_b), .i_wbe_b(wbe_b), .i_wdata_b(wdata_b),
        .i_rlane_0(rlane_0), .i_rlane_1(rlane_1),
        .o_rdata_0(rd10), .o_rdata_1(rd11),
        .i_clr(clr), .o_busy(busy1), .o_datalane(dl1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, lane contents, read registers, clear progress.
    logic [15:0] m_mem [2][8];
    logic [15:0] m_rd  [2][2];
    bit          m_busy[2];
    int          m_cnt [2];

    function automatic int nl(input int d);    return (d == 0) ? 4 : 6; endfunction
    function automatic bit zl(input int d);    return d == 1;           endfunction
    function automatic bit byp(input int d);   return d == 0;           endfunction
    function automatic int lane_of(input int d, input logic [2:0] l);
        return (d == 0) ? int'(l[1:0]) : int'(l);
    endfunction

    task automatic model_step();
        logic [15:0] nm [8];
        int la, lb, rl;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                for (int k = 0; k < 8; k++) m_mem[d][k] = '0;
                m_rd[d][0] = '0;
                m_rd[d][1] = '0;
                m_busy[d]  = 1'b0;
                m_cnt[d]   = 0;
            end else begin
                for (int k = 0; k < 8; k++) nm[k] = m_mem[d][k];
                la = lane_of(d, wlane_a);
                lb = lane_of(d, wlane_b);
                if (wr_a && !m_busy[d] && la < nl(d) && !(zl(d) && la == 0))
                    for (int j = 0; j < 2; j++) if (wbe_a[j]) nm[la][8*j +: 8] = wdata_a[8*j +: 8];
                if (wr_b && !m_busy[d] && lb < nl(d) && !(zl(d) && lb == 0))
                    for (int j = 0; j < 2; j++) if (wbe_b[j]) nm[lb][8*j +: 8] = wdata_b[8*j +: 8];
                for (int p = 0; p < 2; p++) begin
                    rl = lane_of(d, (p == 0) ? rlane_0 : rlane_1);
                    if (rl >= nl(d))  m_rd[d][p] = '0;
                    else if (byp(d))  m_rd[d][p] = nm[rl];
                    else              m_rd[d][p] = m_mem[d][rl];
                end
                if (m_busy[d]) begin
                    nm[m_cnt[d]] = '0;
                    m_cnt[d]++;
                    if (m_cnt[d] == nl(d)) begin
                        m_busy[d] = 1'b0;
                        m_cnt[d]  = 0;
                    end
                end else if (clr) begin
                    m_busy[d] = 1'b1;
                    m_cnt[d]  = 0;
                end
                for (int k = 0; k < 8; k++) m_mem[d][k] = nm[k];
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] v;
        check("d0_rd0", 32'(rd00), 32'(m_rd[0][0]));
        check("d0_rd1", 32'(rd01), 32'(m_rd[0][1]));
        check("d0_busy", 32'(busy0), 32'(m_busy[0]));
        check("d1_rd0", 32'(rd10), 32'(m_rd[1][0]));
        check("d1_rd1", 32'(rd11), 32'(m_rd[1][1]));
        check("d1_busy", 32'(busy1), 32'(m_busy[1]));
        for (int k = 0; k < 4; k++) begin
            v = dl0[k*16 +: 16];
            check($sformatf("d0_lane%0d", k), 32'(v), 32'(m_mem[0][k]));
        end
        for (int k = 0; k < 6; k++) begin
            v = dl1[k*16 +: 16];
            check($sformatf("d1_lane%0d", k), 32'(v), 32'(m_mem[1][k]));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_a = 0; wr_b = 0; clr = 0;
        wlane_a = 0; wlane_b = 0; wbe_a = 0; wbe_b = 0;
        wdata_a = 0; wdata_b = 0;
    endtask

    int bcnt0, bcnt1;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) m_mem[d][k] = '0;
            m_rd[d][0] = '0; m_rd[d][1] = '0; m_busy[d] = 0; m_cnt[d] = 0;
        end
        rst = 0; rlane_0 = 0; rlane_1 = 0;
        idle_inputs();
        @(negedge clk);

        // Reset holds off a concurrent write.
        wr_a = 1; wlane_a = 3'd1; wbe_a = 2'b11; wdata_a = 16'h00AA;
        cycle();
        cycle();
        check("rst_dl0_lo", dl0[31:0], 32'h0);
        check("rst_dl0_hi", dl0[63:32], 32'h0);
        check("rst_busy0", 32'(busy0), 32'h0);
        rst = 1;
        idle_inputs();

        // Byte-enable write.
        wr_a = 1; wlane_a = 3'd2; wbe_a = 2'b11; wdata_a = 16'h1234;
        cycle();
        wbe_a = 2'b10; wdata_a = 16'hABCD; rlane_0 = 3'd2;
        cycle();
        check("be_byp_rd0", 32'(rd00), 32'h0000AB34);
        check("be_nobyp_rd0", 32'(rd10), 32'h00001234);
        wr_a = 0;
        cycle();
        check("be_lane2", 32'(dl0[47:32]), 32'h0000AB34);
        check("be_rd0_next", 32'(rd10), 32'h0000AB34);

        // Same-lane collision, B wins on shared bytes.
        wr_a = 1; wlane_a = 3'd1; wbe_a = 2'b11; wdata_a = 16'h1111;
        wr_b = 1; wlane_b = 3'd1; wbe_b = 2'b01; wdata_b = 16'h2222;
        rlane_1 = 3'd1;
        cycle();
        check("col_lane1", 32'(dl0[31:16]), 32'h00001122);
        check("col_byp_rd1", 32'(rd01), 32'h00001122);
        check("col_nobyp_rd1", 32'(rd11), 32'h00000000);
        idle_inputs();

        // Lane 0 hardwired to zero on dut1, concurrent B write lands.
        wr_a = 1; wlane_a = 3'd0; wbe_a = 2'b11; wdata_a = 16'h00FF;
        wr_b = 1; wlane_b = 3'd3; wbe_b = 2'b11; wdata_b = 16'h3333;
        rlane_0 = 3'd0;
        cycle();
        idle_inputs();
        cycle();
        check("z_d1_lane0", 32'(dl1[15:0]), 32'h0);
        check("z_d1_lane3", 32'(dl1[63:48]), 32'h00003333);
        check("z_d1_rd0", 32'(rd10), 32'h0);
        check("z_d0_lane0", 32'(dl0[15:0]), 32'h000000FF);

        // Out-of-range lanes on dut1 (6 and 7).
        wr_a = 1; wlane_a = 3'd6; wbe_a = 2'b11; wdata_a = 16'h7777;
        rlane_0 = 3'd7;
        cycle();
        idle_inputs();
        cycle();
        check("oor_d1_rd0", 32'(rd10), 32'h0);

        // Clear with a mid-clear write that must be dropped.
        for (int i = 0; i < 4; i++) begin
            wr_a = 1; wlane_a = 3'(i); wbe_a = 2'b11; wdata_a = 16'(17 * (i + 1));
            cycle();
        end
        idle_inputs();
        clr = 1;
        cycle();
        clr = 0;
        bcnt0 = int'(busy0);
        bcnt1 = int'(busy1);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                wr_a = 1; wlane_a = 3'd3; wbe_a = 2'b11; wdata_a = 16'h0099;
            end
            cycle();
            wr_a = 0;
            bcnt0 += int'(busy0);
            bcnt1 += int'(busy1);
        end
        check("clr_busy_cycles_d0", 32'(bcnt0), 32'd4);
        check("clr_busy_cycles_d1", 32'(bcnt1), 32'd6);
        check("clr_d0_lane3", 32'(dl0[63:48]), 32'h0);
        check("clr_d0_all", dl0[31:0] | dl0[63:32], 32'h0);

        // Reset in the middle of a clear, then restart from lane 0.
        for (int i = 0; i < 4; i++) begin
            wr_a = 1; wlane_a = 3'(i); wbe_a = 2'b11; wdata_a = 16'(16'h0101 * (i + 1));
            cycle();
        end
        idle_inputs();
        clr = 1;
        cycle();
        clr = 0;
        cycle();
        rst = 0;
        cycle();
        check("mrst_busy0", 32'(busy0), 32'h0);
        check("mrst_dl0", dl0[31:0] | dl0[63:32], 32'h0);
        rst = 1;
        wr_a = 1; wlane_a = 3'd1; wbe_a = 2'b11; wdata_a = 16'h5555;
        cycle();
        idle_inputs();
        clr = 1;
        cycle();
        clr = 0;
        cycle();
        check("restart_lane1_kept", 32'(dl0[31:16]), 32'h00005555);
        cycle();
        check("restart_lane1_cleared", 32'(dl0[31:16]), 32'h0);
        for (int i = 0; i < 8; i++) cycle();

        // Randomized traffic, including occasional resets and clears.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(63) != 0);
            wr_a    = 1'($urandom_range(1));
            wr_b    = 1'($urandom_range(1));
            wlane_a = 3'($urandom_range(7));
            wlane_b = 3'($urandom_range(7));
            wbe_a   = 2'($urandom_range(3));
            wbe_b   = 2'($urandom_range(3));
            wdata_a = 16'($urandom);
            wdata_b = 16'($urandom);
            rlane_0 = 3'($urandom_range(7));
            rlane_1 = 3'($urandom_range(7));
            clr     = ($urandom_range(15) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
